// File: rtl/result_window_accum_if.sv
// Handshake bundle between the datapath, the window accumulator and its consumer.
// The sample side is in_*/input_data/flush; the summary side is out_*/output_data.
interface result_window_accum_if #(
  parameter int DATA_W = 24,
  parameter int SUM_W  = 27,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] input_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  output_data;
  logic [DATA_W-1:0] out_checksum;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, input_data, flush, out_ready,
    input  in_ready, out_valid, output_data, out_checksum, out_max, out_count
  );

  modport slave (
    input  in_valid, input_data, flush, out_ready,
    output in_ready, out_valid, output_data, out_checksum, out_max, out_count
  );
endinterface

// File: rtl/result_window_accum.sv
// Accumulates sum, XOR checksum and maximum over windows of accepted samples and
// presents each window summary through a valid/ready handshake.
module result_window_accum #(
  parameter int DATA_W = 24,
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1),
  parameter int SUM_W  = (WINDOW == 1) ? DATA_W : DATA_W + $clog2(WINDOW)
) (
  input logic                   clk,
  input logic                   rst_n,
  result_window_accum_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic [DATA_W-1:0] max_q, max_d;

  logic              accept;
  logic              first;
  logic              close;
  logic [CNT_W-1:0]  cnt_inc;

  // The accumulators double as the summary registers: they are frozen in HOLD,
  // and the first sample of the next window reloads them instead of combining.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    in_ready_d = in_ready_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    xor_d      = xor_q;
    max_d      = max_q;
    accept     = bus.in_valid && in_ready_q;
    first      = (cnt_q == '0);
    cnt_inc    = cnt_q + CNT_W'(1);
    close      = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          cnt_d = cnt_inc;
          if (first) begin
            sum_d = SUM_W'(bus.input_data);
            xor_d = bus.input_data;
            max_d = bus.input_data;
          end else begin
            sum_d = sum_q + SUM_W'(bus.input_data);
            xor_d = xor_q ^ bus.input_data;
            if (bus.input_data > max_q) max_d = bus.input_data;
          end
        end
        // An empty window is never closed: flush needs a held or incoming sample.
        close = (accept && (cnt_inc == CNT_W'(WINDOW))) ||
                (bus.flush && (!first || accept));
        if (close) begin
          state_d    = HOLD;
          in_ready_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d    = ACCUM;
          in_ready_d = 1'b1;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d    = ACCUM;
        in_ready_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      xor_q      <= '0;
      max_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      xor_q      <= xor_d;
      max_q      <= max_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.output_data  = sum_q;
  assign bus.out_checksum = xor_q;
  assign bus.out_max      = max_q;
  assign bus.out_count    = cnt_q;

endmodule

// File: tb/tb_result_window_accum.sv
// Bench for result_window_accum (WINDOW=4): directed cases followed by random traffic,
// all checked against a queue-based window model.
module tb_result_window_accum;
  localparam int DATA_W = 24;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int SUM_W  = DATA_W + $clog2(WINDOW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_window_accum_if #(.DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();

  result_window_accum #(
    .DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: samples of the open window, and the summary awaiting handshake.
  logic [DATA_W-1:0] win_q[$];
  bit                pend;
  bit                started;
  logic [SUM_W-1:0]  e_sum;
  logic [DATA_W-1:0] e_xor;
  logic [DATA_W-1:0] e_max;
  int                e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    pend    = 1'b0;
    started = 1'b0;
  endtask

  task automatic summarize();
    e_sum = '0;
    e_xor = '0;
    e_max = '0;
    foreach (win_q[i]) begin
      e_sum = e_sum + SUM_W'(win_q[i]);
      e_xor = e_xor ^ win_q[i];
      if (win_q[i] > e_max) e_max = win_q[i];
    end
    e_cnt = win_q.size();
    win_q.delete();
    pend = 1'b1;
  endtask

  // One clock: drive inputs, check outputs on the falling edge, then advance the model.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit ordy);
    bit exp_ready;
    bit acc;
    bus.in_valid   = v;
    bus.input_data = d;
    bus.flush      = f;
    bus.out_ready  = ordy;
    @(negedge clk);
    exp_ready = started && !pend;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(pend));
    if (pend) begin
      check("sum", 32'(bus.output_data), 32'(e_sum));
      check("checksum", 32'(bus.out_checksum), 32'(e_xor));
      check("max", 32'(bus.out_max), 32'(e_max));
      check("count", 32'(bus.out_count), 32'(e_cnt));
    end
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    started = 1'b1;
    if (pend) begin
      if (ordy) pend = 1'b0;
    end else begin
      if (acc) win_q.push_back(d);
      if (win_q.size() == WINDOW || (f && win_q.size() > 0)) summarize();
    end
  endtask

  // Constant expectations for a summary that should be on the outputs right now.
  task automatic expect_summary(input logic [SUM_W-1:0] s, input logic [DATA_W-1:0] x,
                                input logic [DATA_W-1:0] m, input int c);
    check("tp_valid", 32'(bus.out_valid), 32'd1);
    check("tp_sum", 32'(bus.output_data), 32'(s));
    check("tp_checksum", 32'(bus.out_checksum), 32'(x));
    check("tp_max", 32'(bus.out_max), 32'(m));
    check("tp_count", 32'(bus.out_count), 32'(c));
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.input_data = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_sum", 32'(bus.output_data), 32'd0);
    check("rst_checksum", 32'(bus.out_checksum), 32'd0);
    check("rst_max", 32'(bus.out_max), 32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit                v, f, ordy;
    logic [DATA_W-1:0] d;

    apply_reset();
    step(0, '0, 0, 1);

    // 1,2,3,4 back-to-back with the consumer always ready.
    step(1, 24'd1, 0, 1);
    step(1, 24'd2, 0, 1);
    step(1, 24'd3, 0, 1);
    step(1, 24'd4, 0, 1);
    expect_summary(26'd10, 24'd4, 24'd4, 4);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // All-ones samples reach the top of the sum range.
    repeat (4) step(1, 24'hFFFFFF, 0, 1);
    expect_summary(26'h3FFFFFC, 24'd0, 24'hFFFFFF, 4);
    step(0, '0, 0, 1);

    // Flush of a partial window, then a flush with nothing buffered.
    step(1, 24'd5, 0, 1);
    step(1, 24'd9, 0, 1);
    step(0, '0, 1, 1);
    expect_summary(26'd14, 24'd12, 24'd9, 2);
    step(0, '0, 0, 1);
    step(0, 'x, 1, 1);
    check("flush_empty", 32'(bus.out_valid), 32'd0);
    step(0, 'x, 0, 1);

    // Backpressure holds the summary and blocks new samples.
    step(1, 24'd100, 0, 0);
    step(1, 24'd200, 0, 0);
    step(1, 24'd300, 0, 0);
    step(1, 24'd50, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_summary(26'd650, 24'h1B2, 24'd300, 4);
      step(1, 24'd999, 1, 0);
    end
    step(0, '0, 0, 1);
    repeat (4) step(1, 24'd7, 0, 1);
    expect_summary(26'd28, 24'd0, 24'd7, 4);
    step(0, '0, 0, 1);

    // Flush in the same cycle as an accepted sample.
    step(1, 24'd3, 0, 1);
    step(1, 24'd6, 1, 1);
    expect_summary(26'd9, 24'd5, 24'd6, 2);
    step(0, '0, 0, 1);

    // Asynchronous reset in the middle of a window.
    step(1, 24'd1, 0, 1);
    step(1, 24'd2, 0, 1);
    apply_reset();
    step(0, '0, 0, 1);
    repeat (4) step(1, 24'd8, 0, 1);
    expect_summary(26'd32, 24'd0, 24'd8, 4);
    step(0, '0, 0, 1);

    // Random traffic with one asynchronous reset partway through.
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      f    = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) d = {DATA_W{1'b1}};
      else                           d = DATA_W'($urandom);
      if (!v && $urandom_range(0, 3) == 0) d = 'x;
      if (i == 200) apply_reset();
      step(v, d, f, ordy);
    end
    repeat (3) step(0, '0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
